// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary to packed BCD converter
//
// Purpose:
//   Converts an unsigned binary value to packed BCD, one shift per clock. The
//   result register only updates at the end of a conversion, so downstream
//   display logic never sees intermediate values. Values that do not fit in
//   DIGITS decimal digits produce all-ones (4'hF per digit) and set overflow.
//
// Ports:
//   clk       in   1          system clock, rising edge
//   rst_n     in   1          asynchronous active-low reset
//   start     in   1          conversion request, sampled only when idle
//   bin       in   BIN_W      binary value, latched when start is accepted
//   busy      out  1          high while shifting
//   done      out  1          one-cycle pulse, bcd/overflow updated same cycle
//   bcd       out  4*DIGITS   packed BCD result, digit 0 in bits [3:0]
//   overflow  out  1          last accepted bin exceeded 10^DIGITS-1

module bin2bcd_seq #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    // Largest value representable in DIGITS decimal digits.
    function automatic logic [63:0] max_value(input int n);
        logic [63:0] v;
        v = 64'd1;
        for (int i = 0; i < n; i++) begin
            v = v * 64'd10;
        end
        return v - 64'd1;
    endfunction

    localparam logic [63:0]      MAX_VAL  = max_value(DIGITS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q;
    logic [BIN_W-1:0]   sr_q;
    logic [BCD_W-1:0]   acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               ovf_q;

    logic [BCD_W-1:0]       acc_adj;
    logic [BCD_W+BIN_W-1:0] shifted;
    logic                   bin_too_big;

    assign bin_too_big = (64'(bin) > MAX_VAL);

    // Add-3 correction on every nibble that would reach 10 or more after the
    // shift. A nibble above 9 can only appear on overflowing inputs; its
    // wrap-around is harmless because the result is forced to all-ones.
    always_comb begin
        acc_adj = acc_q;
        for (int d = 0; d < DIGITS; d++) begin
            if (acc_q[4*d +: 4] >= 4'd5) begin
                acc_adj[4*d +: 4] = acc_q[4*d +: 4] + 4'd3;
            end
        end
    end

    // The accumulator MSB falls off the top here; that is the discarded
    // carry beyond DIGITS.
    assign shifted = {acc_adj, sr_q} << 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            sr_q     <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        sr_q    <= bin;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        ovf_q   <= bin_too_big;
                        busy    <= 1'b1;
                        state_q <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    acc_q <= shifted[BIN_W +: BCD_W];
                    sr_q  <= shifted[BIN_W-1:0];
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        busy    <= 1'b0;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    bcd      <= ovf_q ? {BCD_W{1'b1}} : acc_q;
                    overflow <= ovf_q;
                    done     <= 1'b1;
                    state_q  <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - scoreboard bench for bin2bcd_seq

module tb_bin2bcd_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [13:0] bin;
    logic        busy;
    logic        done;
    logic [15:0] bcd;
    logic        overflow;

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];

    bin2bcd_seq #(.BIN_W(14), .DIGITS(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .bcd      (bcd),
        .overflow (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            edge_n++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic push_exp(input logic [15:0] b, input logic o, input int c);
        exp_t e;
        e.bcd = b;
        e.ovf = o;
        e.cyc = c;
        exp_q.push_back(e);
    endtask

    // Monitor: scoreboard pops on done, plus hold, pulse-width and busy-width checks.
    initial begin
        logic [15:0] hold_bcd;
        logic        hold_ovf;
        logic        prev_done;
        int          busy_cnt;
        exp_t        e;
        hold_bcd  = '0;
        hold_ovf  = 1'b0;
        prev_done = 1'b0;
        busy_cnt  = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_bcd = '0;
                hold_ovf = 1'b0;
                busy_cnt = 0;
            end else if (busy) begin
                busy_cnt++;
            end else if (busy_cnt != 0) begin
                chk("busy_width", 32'(busy_cnt), 32'd14);
                busy_cnt = 0;
            end
            if (done) begin
                chk("done_width", {31'b0, prev_done}, 32'd0);
                if (exp_q.size() == 0) begin
                    chk("spurious_done", {31'b0, done}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("bcd", {16'b0, bcd}, {16'b0, e.bcd});
                    chk("overflow", {31'b0, overflow}, {31'b0, e.ovf});
                    chk("done_edge", 32'(edge_n), 32'(e.cyc));
                    hold_bcd = e.bcd;
                    hold_ovf = e.ovf;
                end
            end else begin
                chk("bcd_hold", {16'b0, bcd}, {16'b0, hold_bcd});
                chk("ovf_hold", {31'b0, overflow}, {31'b0, hold_ovf});
            end
            prev_done = done;
        end
    end

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
            @(negedge clk);
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic conv(input logic [13:0] v, input logic [15:0] eb, input logic eo);
        @(negedge clk);
        bin   = v;
        start = 1'b1;
        push_exp(eb, eo, edge_n + 16);
        @(negedge clk);
        start = 1'b0;
        drain();
    endtask

    initial begin
        int a;
        rst_n = 1'b0;
        start = 1'b0;
        bin   = '0;
        repeat (2) @(negedge clk);
        chk("rst_bcd", {16'b0, bcd}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_ovf", {31'b0, overflow}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        conv(14'd0,     16'h0000, 1'b0);
        conv(14'd1234,  16'h1234, 1'b0);
        conv(14'd9999,  16'h9999, 1'b0);
        conv(14'd10000, 16'hFFFF, 1'b1);
        conv(14'd10,    16'h0010, 1'b0);

        // start during SHIFT is ignored and bin changes do not disturb the conversion
        @(negedge clk);
        bin   = 14'd42;
        start = 1'b1;
        push_exp(16'h0042, 1'b0, edge_n + 16);
        a = edge_n + 1;
        @(negedge clk);
        start = 1'b0;
        while (edge_n != a + 4) @(negedge clk);
        bin   = 14'd77;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();

        // reset mid-conversion: no done, outputs back to reset values
        @(negedge clk);
        bin   = 14'd500;
        start = 1'b1;
        a = edge_n + 1;
        @(negedge clk);
        start = 1'b0;
        while (edge_n != a + 6) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_bcd", {16'b0, bcd}, 32'd0);
        chk("midrst_done", {31'b0, done}, 32'd0);
        repeat (12) @(negedge clk);
        rst_n = 1'b1;
        conv(14'd500, 16'h0500, 1'b0);

        // start held high: back-to-back conversions every 16 cycles
        @(negedge clk);
        bin   = 14'd16383;
        start = 1'b1;
        push_exp(16'hFFFF, 1'b1, edge_n + 16);
        push_exp(16'h0007, 1'b0, edge_n + 32);
        a = edge_n + 1;
        @(negedge clk);
        bin = 14'd7;
        while (edge_n != a + 16) @(negedge clk);
        start = 1'b0;
        drain();

        repeat (20) @(negedge clk);
        chk("final_queue", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
